mips_cache_data_assoc: RTL and testbench
========================================

Name: mips_cache_data_assoc

Overview:
Parametrised N-way set-associative, write-through data cache. It is the successor of mips_cache_data and sits between the MIPS CPU data port and the data memory bus. Set count, way count and fill latency tolerance are generic, and victim selection uses true LRU. It adds write-through with back-pressure, allocates on full-word write misses without stalling, and merges partial-word write misses after a fill.

Parameters:
WAYS, 4, associativity; power of 2, range 1..8
SET_BITS, 3, log2 of set count (default 8 sets); one 32-bit word per line
ADDR_W, 32, byte address width; tag = ADDR_W-2-SET_BITS bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
addr  in  32  CPU byte address; bits [1:0] ignored
read_en  in  1  CPU read request
write_en  in  1  CPU write request; read_en and write_en are never both high
writedata  in  32  CPU write data
byte_en  in  4  CPU byte enables for writes
readdata  out  32  read data; valid when read_en=1 and stall=0
stall  out  1  CPU must hold its request while high
mem_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}
mem_read_en  out  1  fill request; held high until mem_dvalid
mem_readdata  in  32  fill data
mem_dvalid  in  1  single-cycle strobe; fill data valid
mem_write_en  out  1  write-through request
mem_writedata  out  32  equals writedata
mem_byte_en  out  4  equals byte_en
mem_waitrequest  in  1  memory not ready; write held while high

Behaviour:
- Address split: index = addr[SET_BITS+1:2], tag = addr[ADDR_W-1:SET_BITS+2].
- Storage: per way and set, one valid bit, one tag, one data word, and one age counter of log2(WAYS) bits.
- Reset (rst=0 at a clk edge):
  - all valid bits cleared; age[w] of every set = w;
  - FSM to IDLE;
  - stall=0, mem_read_en=0, mem_write_en=0, readdata=0.
- Reset has priority over everything. Reset during FILL abandons the fill, and a mem_dvalid arriving afterwards is ignored.
- Hit: valid and tag match in any way. Lookup is combinational.
- FSM states IDLE and FILL.
- IDLE, read hit:
  - readdata = hit-way data in the same cycle, stall=0;
  - ages updated at the edge.
- IDLE, read miss:
  - stall=1 combinationally in the same cycle;
  - next state FILL.
- IDLE, write hit:
  - cache word updated at the edge for the bytes enabled;
  - mem_write_en=1 in the same cycle;
  - stall = mem_waitrequest; the cache update happens only on the edge where stall=0.
- IDLE, write miss with byte_en=4'b1111:
  - allocate victim way, write full word, set valid;
  - write-through as for a hit; never stalls beyond mem_waitrequest.
- IDLE, write miss with partial byte_en:
  - stall=1; next state FILL;
  - after the fill the request becomes a write hit and merges.
- FILL:
  - mem_read_en=1, stall=1;
  - on mem_dvalid: victim way <- {valid=1, tag, mem_readdata}, ages updated, next state IDLE;
  - the following cycle re-looks-up, hits, and drops stall. Miss penalty = fill latency + 1 cycle.
- Victim selection: lowest-index invalid way; otherwise the way with age = WAYS-1.
- LRU update on access of way w: every way with age < age[w] increments; age[w] <- 0. Ages in a set always remain a permutation of 0..WAYS-1.
- No request (read_en=0, write_en=0): no state change, stall=0, memory outputs low.
- WAYS=1 degenerates to direct-mapped; the age logic is removed.
- A changed addr while stall=1 is a CPU protocol violation. Behaviour is undefined and is flagged by an assertion.

Optional Feature:
- Macro CACHE_STATS_EN defined:
  - adds outputs stat_hits[31:0], stat_misses[31:0] and stat_evictions[31:0];
  - all three cleared on reset and saturating at 32'hFFFFFFFF;
  - hits count per completed request that hit on first lookup;
  - misses count per FSM entry to FILL, or per full-word write allocate;
  - evictions count per allocation that replaces a valid line.
- Macro not defined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
1. Reset, then idle for 3 cycles -> stall=0, mem_read_en=0, mem_write_en=0 throughout.
2. Read words 0x00..0x1C with memory DVALID delay 3 -> each read stalls exactly 4 cycles. Second pass over the same addresses -> zero stall cycles and identical readdata.
3. Write i*i to 0x00..0x1C with byte_en=1111 on hits, mem_waitrequest=0 -> no stalls and mem_write_en pulses. Readback returns 0,1,4,...,49. Repeat with mem_waitrequest high for 2 cycles -> stall high exactly 2 cycles per write.
4. With WAYS=4, read 0x00, 0x20, 0x40, 0x60, then again -> the second pass has no stalls. Then read 0x80 -> 0x00 (LRU) is evicted. Re-reading 0x20 does not stall; re-reading 0x00 stalls.
5. After reset, write 0x12345678 to 0x04 with byte_en=0101 while memory holds 0xAABBCCDD -> stall for fill, then readback 0xAA34CC78. A full-word write miss to 0x08 -> no fill (mem_read_en stays 0).
6. Assert rst=0 while in FILL -> next cycle IDLE, stall=0, the line stays invalid, and the late mem_dvalid does not write the cache.

Source files
------------

// File: rtl/mips_cache_data_assoc_if.sv
// rtl/mips_cache_data_assoc_if.sv - CPU data port and memory bus bundle for mips_cache_data_assoc
interface mips_cache_data_assoc_if #(
  parameter int ADDR_W = 32
);
  // CPU side
  logic [ADDR_W-1:0] addr;
  logic              read_en;
  logic              write_en;
  logic [31:0]       writedata;
  logic [3:0]        byte_en;
  logic [31:0]       readdata;
  logic              stall;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic [31:0]       mem_readdata;
  logic              mem_dvalid;
  logic              mem_write_en;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byte_en;
  logic              mem_waitrequest;

  // The cache: serves the CPU, drives the memory bus
  modport slave (
    input  addr, read_en, write_en, writedata, byte_en,
    input  mem_readdata, mem_dvalid, mem_waitrequest,
    output readdata, stall,
    output mem_addr, mem_read_en, mem_write_en, mem_writedata, mem_byte_en
  );

  // The environment: CPU and data memory
  modport master (
    output addr, read_en, write_en, writedata, byte_en,
    output mem_readdata, mem_dvalid, mem_waitrequest,
    input  readdata, stall,
    input  mem_addr, mem_read_en, mem_write_en, mem_writedata, mem_byte_en
  );
endinterface

// File: rtl/mips_cache_data_assoc.sv
// rtl/mips_cache_data_assoc.sv - N-way set-associative write-through data cache with true LRU (optional CACHE_STATS_EN counters)
module mips_cache_data_assoc #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3,
  parameter int ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_cache_data_assoc_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses,
  output logic [31:0]            stat_evictions
`endif
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - 2 - SET_BITS;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t           state_q;
  logic             mem_read_en_q;
  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];

  logic [SET_BITS-1:0] req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    acc_way;
  logic                full_word;
  logic                stall_c;
  logic                mem_we_c;
  logic                go_fill;
  logic                wr_upd;
  logic                fill_upd;
  logic                line_wr;
  logic                age_upd;
  logic [31:0]         merged;
  logic [31:0]         wdata_d;

  assign req_idx   = bus.addr[SET_BITS+1:2];
  assign req_tag   = bus.addr[ADDR_W-1:SET_BITS+2];
  assign full_word = &bus.byte_en;

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: first empty way, else the least recently used one
  always_comb begin
    logic have_inv;
    have_inv = 1'b0;
    victim   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!have_inv && !valid_q[req_idx][w]) begin
        have_inv = 1'b1;
        victim   = WAY_W'(w);
      end
    end
    if (!have_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Request decode: stall, write-through, fill start and line update strobes
  always_comb begin
    stall_c  = 1'b0;
    mem_we_c = 1'b0;
    go_fill  = 1'b0;
    wr_upd   = 1'b0;
    fill_upd = 1'b0;
    if (state_q == S_FILL) begin
      stall_c  = 1'b1;
      fill_upd = bus.mem_dvalid;
    end else if (bus.read_en) begin
      if (!hit) begin
        stall_c = 1'b1;
        go_fill = 1'b1;
      end
    end else if (bus.write_en) begin
      // Hits and full-word misses go straight through; partial misses fetch first
      if (hit || full_word) begin
        mem_we_c = 1'b1;
        stall_c  = bus.mem_waitrequest;
        wr_upd   = !bus.mem_waitrequest;
      end else begin
        stall_c = 1'b1;
        go_fill = 1'b1;
      end
    end
  end

  assign acc_way = (hit && (state_q == S_IDLE)) ? hit_way : victim;
  assign line_wr = wr_upd | fill_upd;
  assign age_upd = line_wr | ((state_q == S_IDLE) && bus.read_en && hit);

  // Byte merge of CPU write data over the current line contents
  always_comb begin
    merged = data_q[req_idx][hit_way];
    for (int b = 0; b < 4; b++) begin
      if (bus.byte_en[b]) merged[8*b +: 8] = bus.writedata[8*b +: 8];
    end
  end

  assign wdata_d = fill_upd ? bus.mem_readdata : merged;

  // FSM, registered fill request and valid bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mem_read_en_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_fill) begin
            state_q       <= S_FILL;
            mem_read_en_q <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.mem_dvalid) begin
            state_q       <= S_IDLE;
            mem_read_en_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          mem_read_en_q <= 1'b0;
        end
      endcase
      if (line_wr) valid_q[req_idx][acc_way] <= 1'b1;
    end
  end

  // Tag and data arrays; contents only matter once the valid bit is set
  always_ff @(posedge clk) begin
    if (rst && line_wr) begin
      tag_q[req_idx][acc_way]  <= req_tag;
      data_q[req_idx][acc_way] <= wdata_d;
    end
  end

  if (WAYS > 1) begin : g_lru
    // True LRU: accessed way becomes youngest, younger ways age by one
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end
      end else if (age_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way) begin
            age_q[req_idx][w] <= '0;
          end else if (age_q[req_idx][w] < age_q[req_idx][acc_way]) begin
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
          end
        end
      end
    end
  end else begin : g_dm
    // Direct-mapped: a single way, nothing to age
    always_comb begin
      for (int s = 0; s < SETS; s++) age_q[s][0] = '0;
    end
  end

  assign bus.readdata      = (bus.read_en && hit) ? data_q[req_idx][hit_way] : 32'h0;
  assign bus.stall         = stall_c;
  assign bus.mem_addr      = bus.addr & ~ADDR_W'(3);
  assign bus.mem_read_en   = mem_read_en_q;
  assign bus.mem_write_en  = mem_we_c;
  assign bus.mem_writedata = bus.writedata;
  assign bus.mem_byte_en   = bus.byte_en;

`ifdef CACHE_STATS_EN
  logic        miss_pend_q;
  logic [31:0] hits_q;
  logic [31:0] misses_q;
  logic [31:0] evict_q;
  logic        req_done;
  logic        alloc;

  assign req_done = (state_q == S_IDLE) && (bus.read_en || bus.write_en) && !stall_c;
  assign alloc    = fill_upd | (wr_upd & ~hit);

  // Saturating event counters; miss_pend_q stops a post-fill hit counting as a hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_pend_q <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
      evict_q     <= '0;
    end else begin
      if (go_fill) miss_pend_q <= 1'b1;
      else if (req_done) miss_pend_q <= 1'b0;
      if (req_done && hit && !miss_pend_q && (hits_q != 32'hFFFFFFFF)) hits_q <= hits_q + 1'b1;
      if ((go_fill || (wr_upd && !hit)) && (misses_q != 32'hFFFFFFFF)) misses_q <= misses_q + 1'b1;
      if (alloc && valid_q[req_idx][victim] && (evict_q != 32'hFFFFFFFF)) evict_q <= evict_q + 1'b1;
    end
  end

  assign stat_hits      = hits_q;
  assign stat_misses    = misses_q;
  assign stat_evictions = evict_q;
`endif

  // The CPU must hold its address while stalled
  a_addr_hold: assert property (@(posedge clk) disable iff (!rst)
    (bus.stall && (bus.read_en || bus.write_en)) |=> $stable(bus.addr));

endmodule

// File: tb/tb_mips_cache_data_assoc.sv
// tb/tb_mips_cache_data_assoc.sv - directed table-driven bench for mips_cache_data_assoc
module tb_mips_cache_data_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_cache_data_assoc_if #(.ADDR_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] st_hits, st_misses, st_evict;
`endif

  mips_cache_data_assoc #(.WAYS(4), .SET_BITS(3), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits(st_hits),
    .stat_misses(st_misses),
    .stat_evictions(st_evict)
`endif
  );

  localparam int OP_RST  = 0;
  localparam int OP_POKE = 1;
  localparam int OP_REQ  = 2;

  typedef struct {
    int          op;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          dly;
    int          wdly;
    int          exp_stall;
    logic        exp_fill;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vq[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mem [0:63];
  int          mem_dly  = 3;
  int          mem_wdly = 0;
  logic        force_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_rst();
    vec_t v;
    v = '{OP_RST, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3, 0, 0, 1'b0, 32'h0};
    vq.push_back(v);
  endtask

  task automatic add_poke(input logic [31:0] a, input logic [31:0] wd);
    vec_t v;
    v = '{OP_POKE, 1'b0, 1'b0, a, wd, 4'h0, 3, 0, 0, 1'b0, 32'h0};
    vq.push_back(v);
  endtask

  task automatic add_rd(input logic [31:0] a, input int stl, input logic fill, input logic [31:0] rdat);
    vec_t v;
    v = '{OP_REQ, 1'b1, 1'b0, a, 32'h0, 4'h0, 3, 0, stl, fill, rdat};
    vq.push_back(v);
  endtask

  task automatic add_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input int wdly, input int stl, input logic fill);
    vec_t v;
    v = '{OP_REQ, 1'b0, 1'b1, a, wd, be, 3, wdly, stl, fill, 32'h0};
    vq.push_back(v);
  endtask

  // Memory model: fill after mem_dly cycles of mem_read_en, write wait of mem_wdly cycles
  initial begin
    int rcnt;
    int wcnt;
    rcnt = 0;
    wcnt = 0;
    bus.mem_dvalid      = 1'b0;
    bus.mem_readdata    = 32'h0;
    bus.mem_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_read_en) rcnt++;
      else rcnt = 0;
      bus.mem_dvalid   = (bus.mem_read_en && (rcnt == mem_dly)) || force_dv;
      bus.mem_readdata = mem[bus.mem_addr[7:2]];
      if (bus.mem_write_en) begin
        if (wcnt < mem_wdly) begin
          bus.mem_waitrequest = 1'b1;
          wcnt++;
        end else begin
          logic [31:0] w;
          bus.mem_waitrequest = 1'b0;
          wcnt = 0;
          w = mem[bus.mem_addr[7:2]];
          for (int b = 0; b < 4; b++)
            if (bus.mem_byte_en[b]) w[8*b +: 8] = bus.mem_writedata[8*b +: 8];
          mem[bus.mem_addr[7:2]] = w;
        end
      end else begin
        bus.mem_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic do_reset();
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Issue one CPU request and hold it until stall drops; called #1 after an edge
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic [31:0] rdata,
                        output logic saw_rd, output logic saw_wt);
    bit done;
    int cyc;
    done = 0;
    cyc  = 0;
    stalls = 0;
    rdata  = 32'h0;
    saw_rd = 1'b0;
    saw_wt = 1'b0;
    bus.addr      = a;
    bus.read_en   = rd;
    bus.write_en  = wr;
    bus.writedata = wd;
    bus.byte_en   = be;
    while (!done) begin
      @(negedge clk);
      if (bus.mem_read_en) saw_rd = 1'b1;
      if (bus.stall) stalls++;
      else begin
        done   = 1;
        rdata  = bus.readdata;
        saw_wt = bus.mem_write_en;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!done && cyc >= 40) begin
        nchk++;
        nerr++;
        $display("FAIL timeout addr=%h: stall still %b after %0d cycles, required 0", a, bus.stall, cyc);
        done = 1;
      end
    end
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
  endtask

  initial begin
    int          stalls;
    logic [31:0] rdata;
    logic        saw_rd;
    logic        saw_wt;

    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 + i;

    // Read fills then hits
    add_rst();
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 4, 1'b1, 32'hC0DE0000 + i);
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 0, 1'b0, 32'hC0DE0000 + i);
    // Write hits without and with memory back-pressure
    for (int i = 0; i < 8; i++) add_wr(32'(i * 4), 32'(i * i), 4'hF, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 0, 1'b0, 32'(i * i));
    for (int i = 0; i < 8; i++) add_wr(32'(i * 4), 32'h100 + 32'(i * i), 4'hF, 2, 2, 1'b0);
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 0, 1'b0, 32'h100 + 32'(i * i));
    // LRU replacement within set 0
    add_rst();
    add_rd(32'h00, 4, 1'b1, 32'h00000100);
    add_rd(32'h20, 4, 1'b1, 32'hC0DE0008);
    add_rd(32'h40, 4, 1'b1, 32'hC0DE0010);
    add_rd(32'h60, 4, 1'b1, 32'hC0DE0018);
    add_rd(32'h00, 0, 1'b0, 32'h00000100);
    add_rd(32'h20, 0, 1'b0, 32'hC0DE0008);
    add_rd(32'h40, 0, 1'b0, 32'hC0DE0010);
    add_rd(32'h60, 0, 1'b0, 32'hC0DE0018);
    add_rd(32'h80, 4, 1'b1, 32'hC0DE0020);
    add_rd(32'h20, 0, 1'b0, 32'hC0DE0008);
    add_rd(32'h00, 4, 1'b1, 32'h00000100);
    // Partial write miss merges after fill; full-word write miss allocates without fill
    add_rst();
    add_poke(32'h04, 32'hAABBCCDD);
    add_wr(32'h04, 32'h12345678, 4'b0101, 0, 4, 1'b1);
    add_rd(32'h04, 0, 1'b0, 32'hAA34CC78);
    add_wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0);
    add_rd(32'h08, 0, 1'b0, 32'hDEADBEEF);

    bus.addr      = 32'h0;
    bus.read_en   = 1'b0;
    bus.write_en  = 1'b0;
    bus.writedata = 32'h0;
    bus.byte_en   = 4'h0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state and idle cycles
    @(negedge clk);
    check("reset readdata", bus.readdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("idle%0d stall", c), {31'b0, bus.stall}, 32'h0);
      check($sformatf("idle%0d mem_read_en", c), {31'b0, bus.mem_read_en}, 32'h0);
      check($sformatf("idle%0d mem_write_en", c), {31'b0, bus.mem_write_en}, 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      case (v.op)
        OP_RST:  do_reset();
        OP_POKE: mem[v.a[7:2]] = v.wd;
        default: begin
          mem_dly  = v.dly;
          mem_wdly = v.wdly;
          do_req(v.rd, v.wr, v.a, v.wd, v.be, stalls, rdata, saw_rd, saw_wt);
          check($sformatf("v%0d a=%h stall cycles", i, v.a), 32'(stalls), 32'(v.exp_stall));
          check($sformatf("v%0d a=%h fill seen", i, v.a), {31'b0, saw_rd}, {31'b0, v.exp_fill});
          check($sformatf("v%0d a=%h mem_write_en", i, v.a), {31'b0, saw_wt}, {31'b0, v.wr});
          if (v.rd) check($sformatf("v%0d a=%h readdata", i, v.a), rdata, v.exp_rdata);
        end
      endcase
    end

    // Reset in the middle of a fill, then a stray mem_dvalid
    do_reset();
    mem_dly  = 6;
    mem_wdly = 0;
    mem[3]   = 32'h600D600D;
    bus.addr    = 32'h0C;
    bus.read_en = 1'b1;
    @(negedge clk);
    check("r6 miss stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("r6 fill mem_read_en", {31'b0, bus.mem_read_en}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.read_en = 1'b0;
    force_dv = 1'b1;
    @(negedge clk);
    check("r6 post-reset stall", {31'b0, bus.stall}, 32'h0);
    check("r6 post-reset mem_read_en", {31'b0, bus.mem_read_en}, 32'h0);
    @(posedge clk);
    #1;
    force_dv = 1'b0;
    do_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, stalls, rdata, saw_rd, saw_wt);
    check("r6 reread stall cycles", 32'(stalls), 32'd7);
    check("r6 reread fill seen", {31'b0, saw_rd}, 32'h1);
    check("r6 reread readdata", rdata, 32'h600D600D);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
